// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate-extension pipeline: extension modes and
// the state of the output skid buffer.
package imm_ext_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ZERO   = 2'd0,
    MODE_SIGN   = 2'd1,
    MODE_UPPER  = 2'd2,
    MODE_BRANCH = 2'd3
  } imm_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension: zero, sign, upper-placement and
// branch-offset (sign-extend then scale by 4).
module imm_extend_core
  import imm_ext_pkg::*;
#(
  parameter int DATA_ORIGINAL_SIZE = 16,
  parameter int DATA_EXTENDED_SIZE = 32
) (
  input  logic [DATA_ORIGINAL_SIZE-1:0] i_value,
  input  logic [MODE_W-1:0]             i_mode,
  output logic [DATA_EXTENDED_SIZE-1:0] o_value
);
  localparam int PAD = DATA_EXTENDED_SIZE - DATA_ORIGINAL_SIZE;

  logic [DATA_EXTENDED_SIZE-1:0] sext;
  assign sext = {{PAD{i_value[DATA_ORIGINAL_SIZE-1]}}, i_value};

  always_comb begin
    o_value = '0;
    case (imm_mode_e'(i_mode))
      MODE_ZERO:   o_value = {{PAD{1'b0}}, i_value};
      MODE_SIGN:   o_value = sext;
      MODE_UPPER:  o_value = {i_value, {PAD{1'b0}}};
      MODE_BRANCH: o_value = sext << 2;
      default:     o_value = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender with a 2-entry skid buffer on the output; o_ready is a
// register so i_ready never reaches the upstream handshake combinationally.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_ORIGINAL_SIZE = 16,
  parameter int DATA_EXTENDED_SIZE = 32,
  parameter int TAG_SIZE           = 5
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DATA_ORIGINAL_SIZE-1:0] i_value,
  input  logic [MODE_W-1:0]             i_mode,
  input  logic [TAG_SIZE-1:0]           i_tag,
  input  logic                          i_flush,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_EXTENDED_SIZE-1:0] o_extended_value,
  output logic [TAG_SIZE-1:0]           o_tag
);

  // Room for the two guard bits that BRANCH shifts into.
  if (DATA_EXTENDED_SIZE < DATA_ORIGINAL_SIZE + 2) begin : g_bad_width
    $error("imm_extend_pipe: DATA_EXTENDED_SIZE must be >= DATA_ORIGINAL_SIZE + 2");
  end

  logic [DATA_EXTENDED_SIZE-1:0] ext_value;

  imm_extend_core #(
    .DATA_ORIGINAL_SIZE(DATA_ORIGINAL_SIZE),
    .DATA_EXTENDED_SIZE(DATA_EXTENDED_SIZE)
  ) u_core (
    .i_value(i_value),
    .i_mode (i_mode),
    .o_value(ext_value)
  );

  skid_state_e                   state;
  logic [DATA_EXTENDED_SIZE-1:0] skid_value;
  logic [TAG_SIZE-1:0]           skid_tag;
  logic                          accept, consume;

  assign accept  = i_valid && o_ready;
  assign consume = o_valid && i_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state            <= ST_EMPTY;
      o_valid          <= 1'b0;
      o_ready          <= 1'b1;
      o_extended_value <= '0;
      o_tag            <= '0;
      skid_value       <= '0;
      skid_tag         <= '0;
    end else if (i_flush) begin
      state   <= ST_EMPTY;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          o_extended_value <= ext_value;
          o_tag            <= i_tag;
          o_valid          <= 1'b1;
          state            <= ST_ONE;
        end
        ST_ONE: begin
          if (accept && consume) begin
            o_extended_value <= ext_value;
            o_tag            <= i_tag;
          end else if (accept) begin
            skid_value <= ext_value;
            skid_tag   <= i_tag;
            o_ready    <= 1'b0;
            state      <= ST_TWO;
          end else if (consume) begin
            o_valid <= 1'b0;
            state   <= ST_EMPTY;
          end
        end
        ST_TWO: if (consume) begin
          o_extended_value <= skid_value;
          o_tag            <= skid_tag;
          o_ready          <= 1'b1;
          state            <= ST_ONE;
        end
        default: begin
          state   <= ST_EMPTY;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized bench for imm_extend_pipe against a queue-based FIFO model with
// arithmetic reference extension.
module tb_imm_extend_pipe;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0, i_ready = 1'b0, i_flush = 1'b0;
  logic        o_ready, o_valid;
  logic [15:0] i_value = '0;
  logic [1:0]  i_mode = '0;
  logic [4:0]  i_tag = '0;
  logic [31:0] o_extended_value;
  logic [4:0]  o_tag;

  imm_extend_pipe #(.DATA_ORIGINAL_SIZE(16), .DATA_EXTENDED_SIZE(32), .TAG_SIZE(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_value(i_value), .i_mode(i_mode), .i_tag(i_tag), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_extended_value(o_extended_value), .o_tag(o_tag)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_fail = 0, n_out = 0;
  bit last_taken = 1'b1;
  logic [36:0] q[$];  // {tag, value}

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(logic [1:0] m, logic [15:0] v);
    int s;
    s = (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    case (m)
      2'd0:    return 32'(v);
      2'd1:    return 32'(s);
      2'd2:    return 32'(v) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  // One clock: check outputs at the falling edge, advance the model, return #1 after the rising edge.
  task automatic cycle();
    logic [36:0] e;
    bit acc;
    @(negedge i_clk);
    chk("vld", {31'b0, o_valid}, {31'b0, q.size() > 0});
    chk("rdy", {31'b0, o_ready}, {31'b0, q.size() < 2});
    acc = i_valid && (q.size() < 2);
    if (o_valid && i_ready && q.size() > 0) begin
      e = q.pop_front();
      chk("data", o_extended_value, e[31:0]);
      chk("tag", {27'b0, o_tag}, {27'b0, e[36:32]});
      n_out++;
    end
    if (i_flush) q.delete();
    else if (acc) q.push_back({i_tag, ref_ext(i_mode, i_value)});
    last_taken = acc || i_flush;
    @(posedge i_clk);
    #1;
  endtask

  // Keeps an offered beat stable until it is taken.
  task automatic offer(bit v);
    if (!i_valid || last_taken) begin
      i_value = 16'($urandom);
      i_mode  = 2'($urandom);
      i_tag   = 5'($urandom);
    end
    i_valid = v;
  endtask

  task automatic directed(logic [1:0] m, logic [15:0] v, logic [4:0] t, logic [31:0] exp);
    i_valid = 1'b1; i_mode = m; i_value = v; i_tag = t; i_ready = 1'b1; i_flush = 1'b0;
    cycle();
    i_valid = 1'b0;
    chk("dir_vld", {31'b0, o_valid}, 32'd1);
    chk("dir_val", o_extended_value, exp);
    chk("dir_tag", {27'b0, o_tag}, {27'b0, t});
    cycle();
  endtask

  initial begin
    int base;
    #12;
    chk("rst_vld", {31'b0, o_valid}, 32'd0);
    chk("rst_rdy", {31'b0, o_ready}, 32'd1);
    chk("rst_val", o_extended_value, 32'd0);
    chk("rst_tag", {27'b0, o_tag}, 32'd0);
    @(negedge i_clk); i_reset = 1'b0;
    @(posedge i_clk); #1;

    directed(2'd1, 16'h8000, 5'd3, 32'hFFFF8000);
    directed(2'd0, 16'h8000, 5'd7, 32'h00008000);
    directed(2'd2, 16'h1234, 5'd9, 32'h12340000);
    directed(2'd3, 16'hFFFF, 5'd1, 32'hFFFFFFFC);
    directed(2'd3, 16'h0004, 5'd31, 32'h00000010);

    // Backpressure: three beats offered, two fit.
    i_ready = 1'b0;
    repeat (3) begin offer(1'b1); cycle(); end
    chk("bp_rdy", {31'b0, o_ready}, 32'd0);
    i_ready = 1'b1;
    repeat (4) begin offer(!last_taken); cycle(); end
    i_valid = 1'b0;
    repeat (3) cycle();

    // Full-rate stream.
    base = n_out;
    i_ready = 1'b1;
    repeat (100) begin offer(1'b1); cycle(); end
    i_valid = 1'b0;
    cycle();
    chk("stream_cnt", 32'(n_out - base), 32'd100);

    // Flush while full with a simultaneous offer.
    i_ready = 1'b0;
    repeat (2) begin offer(1'b1); cycle(); end
    offer(1'b1); i_flush = 1'b1;
    cycle();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("fl_vld", {31'b0, o_valid}, 32'd0);
    chk("fl_rdy", {31'b0, o_ready}, 32'd1);
    i_ready = 1'b1;
    repeat (4) cycle();

    // Asynchronous reset between edges while one beat is held.
    i_ready = 1'b0;
    offer(1'b1); cycle();
    i_valid = 1'b0;
    #3 i_reset = 1'b1;
    #1;
    chk("arst_vld", {31'b0, o_valid}, 32'd0);
    chk("arst_rdy", {31'b0, o_ready}, 32'd1);
    chk("arst_val", o_extended_value, 32'd0);
    chk("arst_tag", {27'b0, o_tag}, 32'd0);
    #2 i_reset = 1'b0;
    q.delete();
    @(posedge i_clk); #1;
    directed(2'd1, 16'h7FFF, 5'd2, 32'h00007FFF);

    // Random traffic with occasional flushes.
    repeat (400) begin
      offer($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 6);
      i_flush = ($urandom_range(0, 39) == 0);
      cycle();
    end
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    repeat (3) cycle();
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter DATA_ORIGINAL_SIZE, default 16, giving the input immediate width.
REQ-002 SHALL have parameter DATA_EXTENDED_SIZE, default 32, giving the output width; legal only if DATA_EXTENDED_SIZE >= DATA_ORIGINAL_SIZE + 2.
REQ-003 SHALL have parameter TAG_SIZE, default 5, giving the width of the sideband tag carried with each value.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_valid  input  1  the upstream beat is valid.
REQ-007 o_ready  output  1  the block accepts a beat this cycle.
REQ-008 i_value  input  DATA_ORIGINAL_SIZE  immediate to extend.
REQ-009 i_mode  input  2  extension mode: 0 ZERO, 1 SIGN, 2 UPPER, 3 BRANCH.
REQ-010 i_tag  input  TAG_SIZE  sideband tag (e.g. destination register), passed through unchanged.
REQ-011 i_flush  input  1  synchronous discard of all held beats.
REQ-012 o_valid  output  1  the output beat is valid.
REQ-013 i_ready  input  1  downstream accepts the output beat.
REQ-014 o_extended_value  output  DATA_EXTENDED_SIZE  extended result.
REQ-015 o_tag  output  TAG_SIZE  tag of the output beat.

Function
REQ-016 Input handshake: a beat SHALL be accepted when i_valid && o_ready.
REQ-017 Output handshake: a beat SHALL be consumed when o_valid && i_ready.
REQ-018 ZERO SHALL produce the upper bits as 0 followed by i_value.
REQ-019 SIGN SHALL produce the upper bits as copies of i_value[MSB] followed by i_value.
REQ-020 UPPER SHALL produce i_value in the top DATA_ORIGINAL_SIZE bits, with the low bits 0.
REQ-021 BRANCH SHALL produce (sign-extended i_value) << 2, truncated to DATA_EXTENDED_SIZE.
REQ-022 The result SHALL be computed combinationally at acceptance and registered; latency is exactly 1 cycle from acceptance to o_valid when the output register is free.
REQ-023 Storage SHALL be a 2-entry skid buffer: an output register plus one skid register.
REQ-024 o_ready SHALL be 1 exactly when the skid register is empty, and SHALL be driven from a register with no combinational path from i_ready.
REQ-025 States:
  - EMPTY: o_valid=0.
  - ONE: output register full.
  - TWO: output register and skid register full, o_ready=0.
REQ-026 Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept without consume -> TWO.
  - ONE + consume without accept -> EMPTY.
  - ONE + accept + consume -> ONE, output register loads the new beat.
  - TWO + consume -> ONE, the skid register moves to the output register.
REQ-027 Ordering SHALL be strictly FIFO; no beat is dropped or duplicated without a flush.
REQ-028 While o_valid=1 and i_ready=0, o_extended_value and o_tag SHALL hold stable.
REQ-029 i_flush SHALL move the block to EMPTY on the next edge and SHALL override a simultaneous accept, which is dropped.

Reset
REQ-030 i_reset SHALL asynchronously force EMPTY: o_valid=0, o_ready=1, o_extended_value=0, o_tag=0, skid register cleared.
REQ-031 Reset asserted mid-operation SHALL discard all held beats; the first accept after deassertion follows REQ-022.

Structure
REQ-032 Mode encodings (MODE_ZERO..MODE_BRANCH) and the mode width SHALL live in the shared package imm_ext_pkg.
REQ-033 The combinational extension SHALL be one sub-module, imm_extend_core (i_value, i_mode -> o_value), instantiated once at the input side.
REQ-034 The parameter legality check of REQ-002 SHALL be an elaboration-time error.

Verification
REQ-035 SIGN, i_value=16'h8000, tag 3, i_ready=1 -> next cycle o_valid=1, o_extended_value=32'hFFFF8000, o_tag=3.
REQ-036 ZERO 16'h8000 -> 32'h00008000; UPPER 16'h1234 -> 32'h12340000; BRANCH 16'hFFFF -> 32'hFFFFFFFC; BRANCH 16'h0004 -> 32'h00000010.
REQ-037 i_ready=0, 3 beats offered back-to-back -> 2 accepted, o_ready=0 from the 3rd cycle; release i_ready -> beats emerge in order, the 3rd is accepted once o_ready=1.
REQ-038 Continuous i_valid=i_ready=1 for 100 beats with random modes -> one beat per cycle, matching the reference model.
REQ-039 i_flush in state TWO with a simultaneous i_valid -> next cycle o_valid=0, o_ready=1, nothing from before the flush ever appears.
REQ-040 i_reset pulsed asynchronously between edges in state ONE -> outputs go to reset values immediately, before the next edge.
